alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Execute-stage controller for the 32-bit ALU. It accepts one decoded data-processing operation at a time over a valid/ready handshake and evaluates the 4-bit condition field against its NZCV flag register. Passing operations are issued to the ALU with carry-in from the flag register; the result and, when the S bit is set, new flags are captured. The result is then presented to write-back over a second valid/ready handshake.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 5, ALU opcode width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous abort of the in-flight operation
- in_valid  in  1  operation offered
- in_ready  out  1  sequencer can accept
- in_cond  in  4  condition field (ARM encoding)
- in_op  in  OP_W  ALU opcode
- in_s  in  1  update flags on completion
- in_a, in_b  in  DATA_W  operands
- in_rd  in  4  destination register tag
- alu_op  out  OP_W  opcode to ALU
- alu_a, alu_b  out  DATA_W  registered operands to ALU
- alu_cin  out  1  carry-in to ALU
- alu_o  in  DATA_W  ALU result
- alu_n, alu_z, alu_v, alu_cout  in  1  ALU flag outputs
- out_valid  in/out: out  1  result available
- out_ready  in  1  write-back accepts
- out_result  out  DATA_W  captured result
- out_rd  out  4  destination tag
- out_we  out  1  1 = commit result; 0 = condition failed or undefined
- out_undef  out  1  opcode in 10011..11111
- flags  out  4  NZCV register {N,Z,C,V}

## Operation
- FSM states: IDLE, EVAL, EXEC, HOLD.
- IDLE: in_ready=1. in_valid&&in_ready latches cond/op/s/a/b/rd and moves to EVAL.
- EVAL: compute cond_pass from latched cond and flags using the ARM table.
  - 0000 EQ through 1101 LE use the standard definitions.
  - 1110 AL always passes; 1111 never passes.
  - Fail: out_we=0, out_undef=0, go to HOLD.
  - Pass with undefined opcode: out_undef=1, out_we=0, go to HOLD.
  - Pass otherwise: go to EXEC.
- EXEC: alu_op/alu_a/alu_b driven from the latched fields; alu_cin = flags[C].
  - At the end of EXEC, capture alu_o into out_result, set out_we=1, and go to HOLD.
  - If s=1, the flag update occurs at the same edge. N←alu_n, Z←alu_z.
  - C←alu_cout and V←alu_v only for arithmetic ops (low 3 bits 010..111); for all other ops C and V are preserved.
- HOLD: out_valid=1. out_result/out_rd/out_we/out_undef stay stable until out_valid&&out_ready, then go to IDLE.
- alu_op, alu_a and alu_b hold their last values outside EXEC (no toggling).
- flush, any state: next state IDLE, out_valid drops, no flag write. Flush in EXEC suppresses that cycle's flag update.
- rst_n=0 (overrides flush), resets:
  - state→IDLE
  - flags→4'b0000
  - out_valid=0, out_we=0, out_undef=0
  - out_result=0, out_rd=0
  - alu_op=0, alu_a=0, alu_b=0
  - in_ready=0 during reset

## Timing
- Handshake at edge T:
  - EVAL in cycle T+1.
  - Passing op: EXEC in T+2; out_valid and new flags visible from T+3.
  - Failed or undefined op: out_valid from T+2, flags unchanged.
- Throughput: at most one op per 4 cycles (passing) or per 3 cycles (fail), plus out_ready stall.
- in_ready=0 in EVAL/EXEC/HOLD. No acceptance in the HOLD release cycle; next accept is the cycle after return to IDLE.
- Condition evaluation uses flags as of EVAL, including an update written by the immediately preceding op.
- out_ready held low: HOLD persists indefinitely, outputs frozen.

## Structure
- Package alu_seq_pkg holds:
  - state enum
  - condition-code localparams COND_EQ..COND_NV
  - ALU opcode localparams
  - flag bit indices FLAG_N/Z/C/V
  - function is_arith(op)
- Sub-module cond_eval is combinational: inputs cond[3:0] and flags[3:0], output pass.
- Sequencer top-level contains the FSM, operand/result registers and flag register; it instantiates cond_eval and connects to the ALU externally.

## Test plan
- Reset: hold rst_n=0 3 cycles with in_valid=1 → in_ready=0, flags=0000, out_valid=0. After release, IDLE and in_ready=1.
- ADDS flag update: cond=1110, op=01100, s=1, a=FFFFFFFF, b=00000001. Expect out_valid at T+3, out_result=0, out_we=1, flags=Z=1/C=1 (bit values per ALU model).
- Condition fail: flags Z=0, cond=0000 (EQ), op=00100. Expect out_valid at T+2, out_we=0, flags unchanged, no EXEC cycle observed on alu_op.
- Carry-in chain: after flags C=1, op=00101, a=5, b=7 → alu_cin=1 in EXEC, out_result=0000000D.
- Backpressure and flush:
  - out_ready=0 for 5 cycles → out_result/out_we stable; accept occurs only after release.
  - Separate run: flush asserted in EXEC of an s=1 op → no out_valid, flags unchanged, in_ready=1 next cycle.
- Undefined op 11000, cond=AL → out_undef=1, out_we=0, flags unchanged. Back-to-back follow-up op accepted on the first IDLE cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and constants for the ALU operation sequencer.
//               Holds the FSM state type, ARM condition codes, ALU opcodes,
//               NZCV flag bit positions and opcode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_EXEC = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // ARM condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // ALU opcodes; the low three bits select the arithmetic class
    localparam logic [4:0] OP_AND       = 5'b00000;
    localparam logic [4:0] OP_ORR       = 5'b00001;
    localparam logic [4:0] OP_SUB       = 5'b00010;
    localparam logic [4:0] OP_RSB       = 5'b00011;
    localparam logic [4:0] OP_ADD       = 5'b00100;
    localparam logic [4:0] OP_ADC       = 5'b00101;
    localparam logic [4:0] OP_SBC       = 5'b00110;
    localparam logic [4:0] OP_RSC       = 5'b00111;
    localparam logic [4:0] OP_EOR       = 5'b01000;
    localparam logic [4:0] OP_BIC       = 5'b01001;
    localparam logic [4:0] OP_CMP       = 5'b01010;
    localparam logic [4:0] OP_CMN       = 5'b01011;
    localparam logic [4:0] OP_ADDX      = 5'b01100;
    localparam logic [4:0] OP_UNDEF_MIN = 5'b10011;

    // NZCV bit positions inside the flag register {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Arithmetic ops own the C and V flags; logical ops leave them alone
    function automatic logic is_arith(input logic [4:0] op);
        return (op[2:0] >= 3'b010);
    endfunction

    function automatic logic is_undef(input logic [4:0] op);
        return (op >= OP_UNDEF_MIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Combinational ARM condition-code evaluator.
//   cond  - 4-bit condition field
//   flags - NZCV flag register {N,Z,C,V}
//   pass  - 1 when the condition holds for the given flags
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import alu_seq_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = w_z;
            COND_NE: pass = ~w_z;
            COND_CS: pass = w_c;
            COND_CC: pass = ~w_c;
            COND_MI: pass = w_n;
            COND_PL: pass = ~w_n;
            COND_VS: pass = w_v;
            COND_VC: pass = ~w_v;
            COND_HI: pass = w_c & ~w_z;
            COND_LS: pass = ~w_c | w_z;
            COND_GE: pass = (w_n == w_v);
            COND_LT: pass = (w_n != w_v);
            COND_GT: pass = ~w_z & (w_n == w_v);
            COND_LE: pass = w_z | (w_n != w_v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Execute-stage controller for the 32-bit ALU. Accepts one
//               decoded operation over in_valid/in_ready, checks its
//               condition against the NZCV register, issues passing ops to
//               the external ALU and presents the result to write-back over
//               out_valid/out_ready.
//   Ports:
//     clk, rst_n, flush          - clock, sync active-low reset, sync abort
//     in_*                       - operation request channel
//     alu_op/a/b/cin, alu_o/...  - external ALU drive and results
//     out_*                      - write-back channel
//     flags                      - NZCV register {N,Z,C,V}
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cond,
    input  logic [OP_W-1:0]   in_op,
    input  logic              in_s,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [3:0]        in_rd,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_o,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_v,
    input  logic              alu_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_rd,
    output logic              out_we,
    output logic              out_undef,
    output logic [3:0]        flags
);

    state_t            r_state;
    logic [3:0]        r_cond;
    logic [OP_W-1:0]   r_op;
    logic              r_s;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [3:0]        r_rd;

    logic              w_pass;
    logic              w_undef;
    logic              w_arith;

    // Evaluated against the live flag register, so an update written by the
    // previous op at its EXEC edge is already visible here.
    cond_eval u_cond_eval (
        .cond  (r_cond),
        .flags (flags),
        .pass  (w_pass)
    );

    assign w_undef  = is_undef(r_op);
    assign w_arith  = is_arith(r_op);

    // Gated by rst_n so the channel reads not-ready while reset is held.
    assign in_ready = rst_n && (r_state == ST_IDLE);
    assign alu_cin  = flags[FLAG_C];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cond     <= 4'd0;
            r_op       <= '0;
            r_s        <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_rd       <= 4'd0;
            flags      <= 4'b0000;
            out_valid  <= 1'b0;
            out_we     <= 1'b0;
            out_undef  <= 1'b0;
            out_result <= '0;
            out_rd     <= 4'd0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else if (flush) begin
            // Abort wins over every state transition, including the EXEC
            // flag write.
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_cond  <= in_cond;
                        r_op    <= in_op;
                        r_s     <= in_s;
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_rd    <= in_rd;
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (!w_pass) begin
                        out_we    <= 1'b0;
                        out_undef <= 1'b0;
                        out_rd    <= r_rd;
                        out_valid <= 1'b1;
                        r_state   <= ST_HOLD;
                    end else if (w_undef) begin
                        out_we    <= 1'b0;
                        out_undef <= 1'b1;
                        out_rd    <= r_rd;
                        out_valid <= 1'b1;
                        r_state   <= ST_HOLD;
                    end else begin
                        // ALU inputs only move when an op is really issued.
                        alu_op  <= r_op;
                        alu_a   <= r_a;
                        alu_b   <= r_b;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    out_result <= alu_o;
                    out_we     <= 1'b1;
                    out_undef  <= 1'b0;
                    out_rd     <= r_rd;
                    out_valid  <= 1'b1;
                    if (r_s) begin
                        flags[FLAG_N] <= alu_n;
                        flags[FLAG_Z] <= alu_z;
                        if (w_arith) begin
                            flags[FLAG_C] <= alu_cout;
                            flags[FLAG_V] <= alu_v;
                        end
                    end
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
